// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide controller.
// Holds the FSM encoding and the iteration count.
package hilo_div_ctrl_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// One restoring-division iteration, purely combinational.
// quo_in doubles as the dividend shifter: MSB leaves, quotient bit enters.
module hilo_div_ctrl_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    always_comb begin
        shifted   = {rem_in, quo_in[WIDTH-1]};
        no_borrow = shifted >= {1'b0, divisor};
        // remainder < divisor keeps the true difference within WIDTH bits
        diff      = shifted[WIDTH-1:0] - divisor;
        rem_out   = no_borrow ? diff : shifted[WIDTH-1:0];
        quo_out   = {quo_in[WIDTH-2:0], no_borrow};
    end

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file with a 32-iteration unsigned restoring divider.
// Owns all state; the divide step itself is a combinational sub-block.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             div_start,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    input  logic             flush,
    input  logic             mt_hi_en,
    input  logic             mt_lo_en,
    input  logic [WIDTH-1:0] mt_value,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             start_ok;

    assign busy     = (state == ST_BUSY);
    assign done     = (state == ST_DONE);
    assign stall    = busy && (div_start || mf_req || mt_hi_en || mt_lo_en);
    assign start_ok = !busy && div_start && !flush;

    hilo_div_ctrl_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            count <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                ST_BUSY: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        count <= count + 1'b1;
                        if (count == CNT_W'(DIV_ITERS - 1)) begin
                            hi    <= rem_nx;
                            lo    <= quo_nx;
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE accept requests identically
                    if (start_ok) begin
                        rem_q <= '0;
                        quo_q <= div_dividend;
                        dvs_q <= div_divisor;
                        count <= '0;
                        state <= ST_BUSY;
                    end else begin
                        if (mt_hi_en) hi <= mt_value;
                        if (mt_lo_en) lo <= mt_value;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
